// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: STEP multiplier bits per clock, optional two's-complement mode.
// Multiplies magnitudes, then negates the 2*WIDTH product when the operand signs differ.
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] LOW,
    output logic [WIDTH-1:0] HIGH
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] product;

    // |-2^(WIDTH-1)| wraps to itself, which is the correct unsigned magnitude.
    assign abs_a   = (mode_signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
    assign abs_b   = (mode_signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
    assign partial = {{WIDTH{1'b0}}, mag_a} * {{(2*WIDTH-STEP){1'b0}}, mag_b[STEP-1:0]};
    assign product = neg ? ((~acc) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            LOW   <= '0;
            HIGH  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        neg   <= mode_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc + (partial << (cnt * STEP));
                    mag_b <= mag_b >> STEP;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    {HIGH, LOW} <= product;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: one STEP=1 and one STEP=4 instance at WIDTH=32.
module tb_seq_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start1, start4;
    logic        modeSigned1, modeSigned4;
    logic [31:0] a1, b1, a4, b4;
    logic        busy1, busy4, done1, done4;
    logic [31:0] low1, high1, low4, high4;

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode_signed(modeSigned1),
        .A(a1), .B(b1), .busy(busy1), .done(done1), .LOW(low1), .HIGH(high1)
    );

    seq_multiplier #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode_signed(modeSigned4),
        .A(a4), .B(b4), .busy(busy4), .done(done4), .LOW(low4), .HIGH(high4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that samples start.
    task automatic applyStimulus(input bit useStep4, input logic ms, input logic [31:0] a, input logic [31:0] b);
        if (useStep4) begin
            start4 = 1'b1; modeSigned4 = ms; a4 = a; b4 = b;
        end else begin
            start1 = 1'b1; modeSigned1 = ms; a1 = a; b1 = b;
        end
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        a1 = 32'hDEADBEEF; b1 = 32'hCAFEF00D; a4 = 32'hDEADBEEF; b4 = 32'hCAFEF00D;
    endtask

    // Counts rising edges until done is seen, bounded so a stuck DUT still reaches the summary.
    task automatic waitDone(input bit useStep4, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(useStep4 ? done4 : done1) && lat < 100);
    endtask

    task automatic checkResult(input bit useStep4, input string tag, input int expLat, input int lat,
                               input logic [63:0] expProd);
        checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, " done"}, 64'(useStep4 ? done4 : done1), 64'd1);
        checkOutput({tag, " busy"}, 64'(useStep4 ? busy4 : busy1), 64'd0);
        checkOutput({tag, " product"}, useStep4 ? {high4, low4} : {high1, low1}, expProd);
    endtask

    initial begin
        int lat;
        int doneCount;

        rst_n = 1'b0;
        start1 = 1'b0; start4 = 1'b0; modeSigned1 = 1'b0; modeSigned4 = 1'b0;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0;
        #2;
        checkOutput("reset busy1", 64'(busy1), 64'd0);
        checkOutput("reset done1", 64'(done1), 64'd0);
        checkOutput("reset prod1", {high1, low1}, 64'd0);
        checkOutput("reset prod4", {high4, low4}, 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Unsigned all-ones, then the pulse must drop the next cycle while the product holds.
        applyStimulus(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput("uns busy after start", 64'(busy1), 64'd1);
        waitDone(1'b0, lat);
        checkResult(1'b0, "uns ffxff", 33, lat, 64'hFFFFFFFE_00000001);
        @(posedge clk); #1;
        checkOutput("uns done one cycle", 64'(done1), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("uns hold idle", {high1, low1}, 64'hFFFFFFFE_00000001);

        // Reset mid-run clears outputs immediately and no done follows.
        applyStimulus(1'b0, 1'b1, 32'h00000003, 32'h00000004);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrun reset busy", 64'(busy1), 64'd0);
        checkOutput("midrun reset done", 64'(done1), 64'd0);
        checkOutput("midrun reset prod", {high1, low1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done1) doneCount++;
        end
        checkOutput("no done after reset", 64'(doneCount), 64'd0);

        applyStimulus(1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000006);
        waitDone(1'b0, lat);
        checkResult(1'b0, "sgn -7x6", 33, lat, 64'hFFFFFFFF_FFFFFFD6);
        @(posedge clk); #1;

        applyStimulus(1'b0, 1'b0, 32'hFFFFFFF9, 32'h00000006);
        waitDone(1'b0, lat);
        checkResult(1'b0, "uns fff9x6", 33, lat, 64'h00000005_FFFFFFD6);
        @(posedge clk); #1;

        applyStimulus(1'b0, 1'b1, 32'h80000000, 32'h80000000);
        waitDone(1'b0, lat);
        checkResult(1'b0, "sgn minxmin", 33, lat, 64'h40000000_00000000);
        @(posedge clk); #1;

        applyStimulus(1'b0, 1'b1, 32'h80000000, 32'h00000001);
        waitDone(1'b0, lat);
        checkResult(1'b0, "sgn minx1", 33, lat, 64'hFFFFFFFF_80000000);
        @(posedge clk); #1;

        // A start while busy is ignored and the previous result stays visible.
        applyStimulus(1'b0, 1'b0, 32'd10, 32'd20);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput("ignored start hold", {high1, low1}, 64'hFFFFFFFF_80000000);
        waitDone(1'b0, lat);
        checkResult(1'b0, "ignored start", 29, lat, 64'd200);
        @(posedge clk); #1;

        applyStimulus(1'b1, 1'b0, 32'h12345678, 32'h9ABCDEF0);
        waitDone(1'b1, lat);
        checkResult(1'b1, "step4 uns", 9, lat, 64'h0B00EA4E_242D2080);

        // Start issued in the done cycle runs back-to-back.
        applyStimulus(1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000002);
        checkOutput("b2b busy", 64'(busy4), 64'd1);
        checkOutput("b2b hold", {high4, low4}, 64'h0B00EA4E_242D2080);
        waitDone(1'b1, lat);
        checkResult(1'b1, "step4 b2b sgn", 9, lat, 64'hFFFFFFFF_FFFFFFFE);
        applyStimulus(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitDone(1'b1, lat);
        checkResult(1'b1, "step4 b2b -1x-1", 9, lat, 64'h00000000_00000001);
        @(posedge clk); #1;

        applyStimulus(1'b1, 1'b1, 32'h00000000, 32'hFFFFFFF9);
        waitDone(1'b1, lat);
        checkResult(1'b1, "step4 zero", 9, lat, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised iterative shift-add multiplier for the ALU's multiply path.
- Replaces the fully unrolled 32-stage array multiplier with a start/done sequential unit that processes STEP multiplier bits per clock.
- Adds a signed (two's-complement) mode and a configurable operand width.
- Produces a 2*WIDTH-bit product split into LOW/HIGH halves, held stable until the next completion.

Parameters:
- WIDTH, 32, operand width in bits; even, >= 4.
- STEP, 1, multiplier bits consumed per cycle; legal values 1, 2, 4; must divide WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- mode_signed  input  1  1 = signed x signed, 0 = unsigned x unsigned; sampled with start.
- A  input  WIDTH  multiplicand; sampled with start.
- B  input  WIDTH  multiplier; sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; LOW/HIGH valid.
- LOW  output  WIDTH  product bits [WIDTH-1:0].
- HIGH  output  WIDTH  product bits [2*WIDTH-1:WIDTH].

Behaviour:
- Reset, asynchronous on rst_n=0: state IDLE, busy=0, done=0, LOW=0, HIGH=0, internal accumulator and counter cleared. Reset mid-operation aborts it; no done is ever issued for that operation.
- States: IDLE, RUN, FINISH. Let N = WIDTH/STEP.
- IDLE: done=0 except in the pulse cycle. On start=1 at edge 0:
  - latch magA = |A| and magB = |B| if mode_signed, else A and B.
  - latch neg = mode_signed & (A[MSB] ^ B[MSB]).
  - clear the 2*WIDTH accumulator and the counter; busy<=1; go to RUN.
- RUN: each edge processes the STEP LSBs of the remaining multiplier:
  - acc <= acc + ((magB[STEP-1:0] * magA) << (cnt*STEP)), or an equivalent shift-right accumulator formulation.
  - magB >>= STEP; cnt++.
  - After N edges (cnt == N-1 on the current edge), go to FINISH.
- FINISH, one edge:
  - {HIGH,LOW} <= neg ? (~acc + 1) : acc, taken modulo 2^(2*WIDTH).
  - done<=1 for exactly one cycle; busy<=0; go to IDLE.
- Latency: start sampled at edge 0 -> done high in the cycle after edge N+1, i.e. N+1 cycles. WIDTH=32, STEP=1 gives 33 cycles; STEP=4 gives 9 cycles.
- busy is high from the cycle after the start edge through the FINISH edge, and low in the done cycle.
- start while busy=1 is ignored; no queuing, operands are not re-latched.
- start in the done cycle is accepted, giving back-to-back operation with no gap.
- LOW/HIGH change only at the FINISH edge and hold otherwise, including across ignored starts.
- A and B may change freely after the start edge.
- Width rules:
  - magnitudes are WIDTH-bit unsigned.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) is representable.
  - the product of the magnitudes fits in 2*WIDTH bits.
  - all intermediate adds are (2*WIDTH)-bit with no overflow.
- Zero operands need no special case: the result is 0 and neg is irrelevant, because the negation of 0 is 0.

Test Plan:
- Reset defaults, WIDTH=32, STEP=1: assert rst_n=0 mid-RUN -> busy=0, done=0, LOW=HIGH=0 immediately. No done follows after release.
- Unsigned, WIDTH=32, STEP=1: A=0xFFFFFFFF, B=0xFFFFFFFF -> HIGH=0xFFFFFFFE, LOW=0x00000001. done asserted exactly 33 cycles after the start edge, for one cycle.
- Signed, WIDTH=32: A=-7 (0xFFFFFFF9), B=6 -> HIGH=0xFFFFFFFF, LOW=0xFFFFFFD6. Same operands unsigned -> HIGH=0x00000005, LOW=0xFFFFFFD6.
- Signed extremes, WIDTH=32: A=B=0x80000000 -> HIGH=0x40000000, LOW=0. A=0x80000000, B=1 -> HIGH=0xFFFFFFFF, LOW=0x80000000.
- STEP=4, WIDTH=32: A=0x12345678, B=0x9ABCDEF0 unsigned -> HIGH=0x0B00EA4E, LOW=0x242D2080. done 9 cycles after start.
- Handshake:
  - pulse start during busy with different operands -> ignored; result matches the first operands.
  - start in the done cycle -> a second result follows N+1 cycles later.
  - LOW/HIGH hold between completions.
